tlp_replay_scheduler: RTL
=========================

Name: tlp_replay_scheduler

Overview:
Transmit-side data-link sequencer for the TLP path. Accepts 96-bit TLPs and assigns each a 12-bit sequence number. Drives the combinational CRC/framing block, stores each 128-bit framed result in an internal replay buffer, and presents it on the link. Consumes ACK/NAK DLLPs to purge the buffer, and schedules replays on NAK or replay-timer expiry, with replay-count rollover signalling.

Parameters:
DEPTH, 8, replay buffer entries; power of two.
SEQ_W, 12, sequence number width.
REPLAY_TIMEOUT, 1024, cycles of no forward progress before a timer replay.
REPLAY_NUM_MAX, 3, replays allowed before rollover.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
tlp_valid  in  1  new TLP offered
tlp_ready  out  1  TLP accepted when tlp_valid && tlp_ready
tlp_data  in  96  TLP header/payload
crc_rdy  out  1  enable to CRC block
crc_tlp  out  96  TLP to CRC block
crc_seq  out  16  {4'h0, seq} to CRC block
crc_data  in  128  framed TLP (seq + TLP + CRC) from CRC block, combinational
tx_valid  out  1  framed TLP on link
tx_ready  in  1  link accepts tx_data
tx_data  out  128  framed TLP
ack_valid  in  1  ACK/NAK DLLP received
ack_nak  in  1  1 = NAK, 0 = ACK
ack_seq  in  SEQ_W  AckNak_Seq_Num
retrain_req  out  1  one-cycle pulse on replay-number rollover
buf_count  out  $clog2(DEPTH+1)  occupied entries
next_seq  out  SEQ_W  NEXT_TRANSMIT_SEQ
acked_seq  out  SEQ_W  ACKD_SEQ

Behaviour:
- Reset values: next_seq=0, acked_seq=4095 (all ones), buf_count=0, wr/rd pointers=0, replay_num=0, timer=0, replay_pending=0, state=IDLE, tlp_ready=0 during reset, tx_valid=0, retrain_req=0, tx_data=0.
- FSM states: IDLE, SEND, REPLAY.
- tlp_ready = (state==IDLE) && (buf_count<DEPTH) && !replay_pending.
- crc_tlp and crc_seq are driven continuously from tlp_data and {4'h0,next_seq}. crc_rdy = tlp_valid && tlp_ready.
- Accept cycle:
  - Write crc_data into buf[wr_ptr] and into the tx_data register.
  - wr_ptr++ (wraps at DEPTH); next_seq++ (mod 2^SEQ_W); buf_count++.
  - IDLE->SEND. tx_valid rises on the next cycle (1-cycle latency).
- SEND: hold tx_valid/tx_data until tx_ready; on the handshake SEND->IDLE. tx_data is stable while tx_valid && !tx_ready.
- ACK/NAK processing, all states:
  - n = (ack_seq - acked_seq) mod 2^SEQ_W.
  - If 0 < n <= buf_count: rd_ptr += n, buf_count -= n, acked_seq = ack_seq, replay_num = 0, timer = 0.
  - If n > buf_count: DLLP is ignored entirely, with no state change.
  - n = 0: no purge.
  - NAK (after any purge) with buf_count_after > 0 sets replay_pending. NAK with buf_count_after = 0 has no further effect.
- Accept and purge in the same cycle: buf_count_next = buf_count + 1 - n.
- Replay timer:
  - Increments each cycle while buf_count>0 and state != REPLAY; held at 0 otherwise.
  - At timer == REPLAY_TIMEOUT-1: set replay_pending, timer = 0.
- Replay start: taken from IDLE when replay_pending; SEND always completes first.
  - If replay_num == REPLAY_NUM_MAX: pulse retrain_req for 1 cycle and replay_num = 0. Otherwise replay_num++.
  - In all cases: clear replay_pending, rp_off = 0, state->REPLAY.
- REPLAY:
  - tx_valid = 1; tx_data = buf[rd_ptr + rp_off] (combinational read).
  - rp_off_next = max(rp_off + (tx_valid && tx_ready) - n, 0), where n is the purge count that cycle.
  - Exit to IDLE when rp_off_next >= buf_count_next.
  - A NAK received in REPLAY purges but sets no new replay_pending.
  - tlp_ready = 0 throughout.
- Sequence wrap: 4095 -> 0. Modular distance is used everywhere; no magnitude compares on raw sequence numbers.
- Full: buf_count == DEPTH deasserts tlp_ready; only an ACK/NAK frees space.
- Reset mid-operation: all state returns to reset values asynchronously and the buffer contents are discarded.

Decomposition:
- Shared package dll_pkg:
  - SEQ_W, TLP_W=96, FRAME_W=128.
  - seq_t typedef.
  - FSM state enum.
  - seq_dist() modular-distance function.
- One natural sub-module: replay_timer (counter with clear, hold and expire pulse). The buffer array stays inline.

Test Plan:
- Single TLP 96'h123456789abcdefffff12345 after reset -> crc_seq=16'h0000 on the accept cycle; tx_valid the next cycle with tx_data == crc_data; buf_count=1, next_seq=1.
- Send 8 TLPs with tx_ready=1 -> tlp_ready=0 at buf_count=8. ACK ack_seq=3 -> buf_count=4, acked_seq=3, tlp_ready=1.
- 3 TLPs (seq 0-2), NAK ack_seq=0 -> purge 1; REPLAY sends seq 1,2 back-to-back; IDLE afterwards; replay_num=1.
- 2 TLPs, no ACK for 1024 cycles -> timer replay of both. Repeat 4 times -> retrain_req pulses on the 4th replay start; replay_num=0.
- Preload next_seq=4094, acked_seq=4093, send 3 TLPs (4094, 4095, 0). ACK ack_seq=0 -> buf_count=0. ACK ack_seq=100 -> ignored.
- Assert rst during REPLAY with buf_count=5 -> tx_valid=0, buf_count=0, next_seq=0, acked_seq=4095 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared data-link-layer types for the TLP transmit path: widths, sequence type,
// sequencer states and the modular sequence-distance helper.
package dll_pkg;

  localparam int SEQ_W   = 12;
  localparam int TLP_W   = 96;
  localparam int FRAME_W = 128;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_REPLAY
  } dll_state_t;

  // Forward distance from b to a; wraps naturally at 2^SEQ_W.
  function automatic seq_t seq_dist(input seq_t a, input seq_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timer: counts cycles without forward progress and pulses o_expire on the
// last count, restarting from zero. Held at zero while not running or cleared.
module replay_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  assign o_expire = i_run && !i_clear && (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (!i_run || i_clear || o_expire)
      r_count <= '0;
    else
      r_count <= r_count + CW'(1);
  end

endmodule

// File: rtl/tlp_replay_scheduler.sv
// Transmit-side data-link sequencer: numbers TLPs, keeps framed copies in a replay
// buffer, purges on ACK/NAK and replays the unacknowledged window on NAK or timeout.
module tlp_replay_scheduler
  import dll_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int REPLAY_TIMEOUT = 1024,
  parameter int REPLAY_NUM_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tlp_valid,
  output logic                       tlp_ready,
  input  logic [TLP_W-1:0]           tlp_data,
  output logic                       crc_rdy,
  output logic [TLP_W-1:0]           crc_tlp,
  output logic [15:0]                crc_seq,
  input  logic [FRAME_W-1:0]         crc_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [FRAME_W-1:0]         tx_data,
  input  logic                       ack_valid,
  input  logic                       ack_nak,
  input  logic [SEQ_W-1:0]           ack_seq,
  output logic                       retrain_req,
  output logic [$clog2(DEPTH+1)-1:0] buf_count,
  output logic [SEQ_W-1:0]           next_seq,
  output logic [SEQ_W-1:0]           acked_seq
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int RN_W  = $clog2(REPLAY_NUM_MAX + 1);

  dll_state_t         r_state, w_state_next;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, w_rd_idx;
  logic [CNT_W-1:0]   r_buf_count, r_rp_off;
  seq_t               r_next_seq, r_acked_seq;
  logic [RN_W-1:0]    r_replay_num;
  logic               r_replay_pending, r_retrain;
  logic [FRAME_W-1:0] r_tx_data;
  logic [FRAME_W-1:0] r_buf [DEPTH];

  seq_t               w_n;
  logic               w_dllp_ok, w_purge_ok, w_accept, w_tx_hs, w_nak_replay;
  logic               w_replay_start, w_replay_done, w_expire, w_timer_run;
  logic [CNT_W-1:0]   w_purge, w_count_after, w_count_next, w_rp_off_next;
  logic [CNT_W:0]     w_rp_sum;

  // A DLLP reaching beyond the buffered window is stale or bogus and is dropped whole.
  assign w_n            = seq_dist(ack_seq, r_acked_seq);
  assign w_dllp_ok      = ack_valid && (w_n <= SEQ_W'(r_buf_count));
  assign w_purge_ok     = w_dllp_ok && (w_n != '0);
  assign w_purge        = w_purge_ok ? CNT_W'(w_n) : '0;
  assign w_count_after  = r_buf_count - w_purge;
  assign w_accept       = tlp_valid && tlp_ready;
  assign w_count_next   = w_count_after + CNT_W'(w_accept);
  assign w_tx_hs        = tx_valid && tx_ready;
  assign w_nak_replay   = w_dllp_ok && ack_nak && (w_count_after != '0) && (r_state != ST_REPLAY);
  assign w_replay_start = (r_state == ST_IDLE) && r_replay_pending;
  assign w_timer_run    = (r_buf_count != '0) && (r_state != ST_REPLAY);
  assign w_rd_idx       = r_rd_ptr + r_rp_off[PTR_W-1:0];

  // Replay offset is relative to rd_ptr, so a purge during replay pulls it back.
  assign w_rp_sum      = {1'b0, r_rp_off} + (CNT_W + 1)'(w_tx_hs);
  assign w_rp_off_next = (w_rp_sum > {1'b0, w_purge}) ? CNT_W'(w_rp_sum - {1'b0, w_purge}) : '0;
  assign w_replay_done = (w_rp_off_next >= w_count_next);

  assign crc_tlp     = tlp_data;
  assign crc_seq     = 16'(r_next_seq);
  assign crc_rdy     = w_accept;
  assign retrain_req = r_retrain;
  assign buf_count   = r_buf_count;
  assign next_seq    = r_next_seq;
  assign acked_seq   = r_acked_seq;

  replay_timer #(.TIMEOUT(REPLAY_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_timer_run),
    .i_clear  (w_purge_ok),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_replay_start)
          w_state_next = ST_REPLAY;
        else if (w_accept)
          w_state_next = ST_SEND;
      end
      ST_SEND:   if (tx_ready) w_state_next = ST_IDLE;
      ST_REPLAY: if (w_replay_done) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tlp_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = r_tx_data;
    case (r_state)
      ST_IDLE:   tlp_ready = !rst && (r_buf_count < CNT_W'(DEPTH)) && !r_replay_pending;
      ST_SEND:   tx_valid = 1'b1;
      ST_REPLAY: begin
        tx_valid = 1'b1;
        tx_data  = r_buf[w_rd_idx];
      end
      default: ;
    endcase
  end

  // Buffer storage carries no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf[r_wr_ptr] <= crc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_buf_count      <= '0;
      r_next_seq       <= '0;
      r_acked_seq      <= '1;
      r_replay_num     <= '0;
      r_retrain        <= 1'b0;
      r_replay_pending <= 1'b0;
      r_rp_off         <= '0;
      r_tx_data        <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_next_seq <= r_next_seq + SEQ_W'(1);
        r_tx_data  <= crc_data;
      end
      r_rd_ptr    <= r_rd_ptr + PTR_W'(w_purge);
      r_buf_count <= w_count_next;
      if (w_purge_ok)
        r_acked_seq <= ack_seq;
      if (w_replay_start)
        r_replay_num <= (r_replay_num == RN_W'(REPLAY_NUM_MAX)) ? '0 : r_replay_num + RN_W'(1);
      else if (w_purge_ok)
        r_replay_num <= '0;
      r_retrain <= w_replay_start && (r_replay_num == RN_W'(REPLAY_NUM_MAX));
      if (w_replay_start)
        r_replay_pending <= 1'b0;
      else if (w_nak_replay || w_expire)
        r_replay_pending <= 1'b1;
      if (w_replay_start)
        r_rp_off <= '0;
      else if (r_state == ST_REPLAY)
        r_rp_off <= w_rp_off_next;
    end
  end

endmodule
